// File: rtl/mux_n_1_rr.sv
// N-to-1 registered multiplexer with valid/ready handshake.
// Fixed-select or round-robin channel choice feeding one output register.
module mux_n_1_rr #(
   parameter int unsigned N  = 8,
   parameter int unsigned W  = 8,
   parameter int unsigned CW = $clog2(N)
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           mode,
   input  logic [CW-1:0]  seleksioni,
   input  logic [N-1:0]   in_valid,
   input  logic [N*W-1:0] in_data,
   output logic [N-1:0]   in_ready,
   output logic           out_valid,
   output logic [W-1:0]   out_data,
   output logic [CW-1:0]  out_ch,
   input  logic           out_ready
);

   logic          load;
   logic          grant_valid;
   logic [CW-1:0] grant_ch;
   logic [W-1:0]  grant_data;
   logic [CW-1:0] rr_ptr;
   logic [CW-1:0] rr_next;
   logic          hi_found;
   logic          lo_found;
   logic [CW-1:0] hi_ch;
   logic [CW-1:0] lo_ch;

   assign load = !out_valid | out_ready;

   // Round-robin: lowest valid index at or above rr_ptr, else lowest valid overall (wrap).
   always_comb begin
      hi_found = 1'b0;
      lo_found = 1'b0;
      hi_ch    = '0;
      lo_ch    = '0;
      for (int i = int'(N) - 1; i >= 0; i--) begin
         if (in_valid[i]) begin
            lo_found = 1'b1;
            lo_ch    = CW'(i);
            if (CW'(i) >= rr_ptr) begin
               hi_found = 1'b1;
               hi_ch    = CW'(i);
            end
         end
      end
   end

   always_comb begin
      grant_valid = 1'b0;
      grant_ch    = '0;
      if (!mode) begin
         // Out-of-range select matches no channel, so it never grants.
         for (int i = 0; i < int'(N); i++) begin
            if (seleksioni == CW'(i) && in_valid[i]) begin
               grant_valid = 1'b1;
               grant_ch    = CW'(i);
            end
         end
      end else if (hi_found) begin
         grant_valid = 1'b1;
         grant_ch    = hi_ch;
      end else if (lo_found) begin
         grant_valid = 1'b1;
         grant_ch    = lo_ch;
      end
   end

   always_comb begin
      grant_data = '0;
      in_ready   = '0;
      for (int i = 0; i < int'(N); i++) begin
         if (grant_ch == CW'(i)) begin
            grant_data  = in_data[i*W +: W];
            in_ready[i] = load & grant_valid;
         end
      end
   end

   assign rr_next = (grant_ch == CW'(N - 1)) ? '0 : grant_ch + CW'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_ch    <= '0;
         rr_ptr    <= '0;
      end else if (load) begin
         if (grant_valid) begin
            out_valid <= 1'b1;
            out_data  <= grant_data;
            out_ch    <= grant_ch;
            if (mode) begin
               rr_ptr <= rr_next;
            end
         end else begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mux_n_1_rr.sv
// Self-checking bench for mux_n_1_rr: a reference model drives a scoreboard of
// expected words, and scenario tasks check the behaviours of interest inline.
module tb_mux_n_1_rr;

   logic        clk;
   logic        rst_n;
   logic        mode;
   logic [2:0]  seleksioni;
   logic [7:0]  in_valid;
   logic [63:0] in_data;
   logic [7:0]  in_ready;
   logic        out_valid;
   logic [7:0]  out_data;
   logic [2:0]  out_ch;
   logic        out_ready;

   logic [4:0]  in_valid5;
   logic [39:0] in_data5;
   logic [4:0]  in_ready5;
   logic        out_valid5;
   logic [7:0]  out_data5;
   logic [2:0]  out_ch5;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state (register contents expected after the next edge).
   logic        m_ov;
   logic [2:0]  m_ptr;
   logic [10:0] sb_q[$];
   logic        mon_en;

   mux_n_1_rr #(.N(8), .W(8)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .mode       (mode),
      .seleksioni (seleksioni),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_ch     (out_ch),
      .out_ready  (out_ready)
   );

   mux_n_1_rr #(.N(5), .W(8)) u_dut5 (
      .clk        (clk),
      .rst_n      (rst_n),
      .mode       (1'b0),
      .seleksioni (3'd7),
      .in_valid   (in_valid5),
      .in_data    (in_data5),
      .in_ready   (in_ready5),
      .out_valid  (out_valid5),
      .out_data   (out_data5),
      .out_ch     (out_ch5),
      .out_ready  (1'b1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [3:0] model_grant(input logic md, input logic [2:0] sel,
                                              input logic [7:0] v, input logic [2:0] ptr);
      if (!md) begin
         if (((v >> sel) & 8'd1) != 8'd0) return {1'b1, sel};
         return 4'd0;
      end
      for (int k = 0; k < 8; k++) begin
         int idx;
         idx = (int'(ptr) + k) % 8;
         if (((v >> idx) & 8'd1) != 8'd0) return {1'b1, 3'(idx)};
      end
      return 4'd0;
   endfunction

   always @(negedge rst_n) begin
      m_ov  = 1'b0;
      m_ptr = 3'd0;
      sb_q.delete();
   end

   // Scoreboard: check handshake and drained words, then predict the next edge.
   always @(negedge clk) begin
      if (rst_n && mon_en) begin
         logic [3:0]  g;
         logic        mload;
         logic [7:0]  exp_rdy;
         logic [10:0] w;
         g       = model_grant(mode, seleksioni, in_valid, m_ptr);
         mload   = !m_ov || out_ready;
         exp_rdy = (mload && g[3]) ? (8'd1 << g[2:0]) : 8'd0;
         n_tests++;
         if (in_ready !== exp_rdy) begin
            n_fail++;
            $display("FAIL sb_in_ready: got %b expected %b at %0t", in_ready, exp_rdy, $time);
         end
         n_tests++;
         if (out_valid !== m_ov) begin
            n_fail++;
            $display("FAIL sb_out_valid: got %b expected %b at %0t", out_valid, m_ov, $time);
         end
         if (m_ov && out_ready) begin
            if (sb_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL sb_empty: drain at %0t with no expected word", $time);
            end else begin
               w = sb_q.pop_front();
               n_tests++;
               if ({out_ch, out_data} !== w) begin
                  n_fail++;
                  $display("FAIL sb_word: got ch%0d %h expected ch%0d %h at %0t",
                           out_ch, out_data, w[10:8], w[7:0], $time);
               end
            end
         end
         if (mload) begin
            if (g[3]) begin
               sb_q.push_back({g[2:0], 8'h10 + {5'd0, g[2:0]}});
               m_ov = 1'b1;
               if (mode) m_ptr = g[2:0] + 3'd1;
            end else begin
               m_ov = 1'b0;
            end
         end
      end
   end

   task automatic test_reset();
      rst_n = 1'b0;
      #2;
      n_tests++;
      if (out_valid !== 1'b0 || out_data !== 8'h00 || out_ch !== 3'd0) begin
         n_fail++;
         $display("FAIL reset_state: got v%b d%h c%0d expected v0 d00 c0",
                  out_valid, out_data, out_ch);
      end
      mode = 1'b0; seleksioni = 3'd3; in_valid = 8'hFF; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic test_fixed();
      for (int k = 0; k < 6; k++) begin
         @(posedge clk); @(negedge clk);
         n_tests++;
         if (out_valid !== 1'b1 || out_data !== 8'h13 || out_ch !== 3'd3 || in_ready !== 8'h08) begin
            n_fail++;
            $display("FAIL fixed_sel3: got v%b d%h c%0d r%b expected v1 d13 c3 r00001000",
                     out_valid, out_data, out_ch, in_ready);
         end
      end
   endtask

   task automatic test_rr_all();
      @(posedge clk); #1 mode = 1'b1;
      for (int k = 0; k < 16; k++) begin
         @(posedge clk); @(negedge clk);
         n_tests++;
         if (out_ch !== 3'(k % 8) || out_data !== 8'h10 + 8'(k % 8)) begin
            n_fail++;
            $display("FAIL rr_seq[%0d]: got c%0d d%h expected c%0d d%h",
                     k, out_ch, out_data, k % 8, 8'h10 + 8'(k % 8));
         end
      end
   endtask

   task automatic test_rr_wrap();
      logic [2:0] exp_seq [4];
      exp_seq = '{3'd7, 3'd2, 3'd7, 3'd2};
      repeat (3) @(posedge clk);
      #1 in_valid = 8'b1000_0100;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); @(negedge clk);
         n_tests++;
         if (out_ch !== exp_seq[k] || out_data !== 8'h10 + {5'd0, exp_seq[k]}) begin
            n_fail++;
            $display("FAIL rr_wrap[%0d]: got c%0d d%h expected c%0d", k, out_ch, out_data,
                     exp_seq[k]);
         end
      end
   endtask

   task automatic test_back_to_back();
      @(posedge clk); #1 out_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); @(negedge clk);
         n_tests++;
         if (in_ready !== 8'h00 || out_valid !== 1'b1 || out_ch !== 3'd7 || out_data !== 8'h17) begin
            n_fail++;
            $display("FAIL stall_hold[%0d]: got r%b v%b c%0d d%h expected r0 v1 c7 d17",
                     k, in_ready, out_valid, out_ch, out_data);
         end
      end
      @(posedge clk); #1 out_ready = 1'b1; in_valid = 8'b0000_0100;
      @(negedge clk);
      n_tests++;
      if (in_ready !== 8'h04 || out_ch !== 3'd7) begin
         n_fail++;
         $display("FAIL drain_fill_pre: got r%b c%0d expected r00000100 c7", in_ready, out_ch);
      end
      @(posedge clk); @(negedge clk);
      n_tests++;
      if (out_valid !== 1'b1 || out_ch !== 3'd2 || out_data !== 8'h12) begin
         n_fail++;
         $display("FAIL drain_fill: got v%b c%0d d%h expected v1 c2 d12",
                  out_valid, out_ch, out_data);
      end
   endtask

   task automatic test_fixed_novalid();
      @(posedge clk); #1 mode = 1'b0; seleksioni = 3'd5; in_valid = 8'hDF;
      @(posedge clk); @(negedge clk);
      n_tests++;
      if (out_valid !== 1'b0 || in_ready !== 8'h00 || out_ch !== 3'd2 || out_data !== 8'h12) begin
         n_fail++;
         $display("FAIL fixed_novalid: got v%b r%b c%0d d%h expected v0 r0 c2 d12",
                  out_valid, in_ready, out_ch, out_data);
      end
      @(posedge clk); #1 seleksioni = 3'd3;
      @(posedge clk); #1 mode = 1'b1; in_valid = 8'hFF;
      @(negedge clk);
      n_tests++;
      if (out_ch !== 3'd3 || out_data !== 8'h13) begin
         n_fail++;
         $display("FAIL fixed_xfer: got c%0d d%h expected c3 d13", out_ch, out_data);
      end
      @(posedge clk); @(negedge clk);
      n_tests++;
      if (out_ch !== 3'd3) begin
         n_fail++;
         $display("FAIL rr_ptr_kept: got c%0d expected c3", out_ch);
      end
   endtask

   task automatic test_async_reset();
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      n_tests++;
      if (out_valid !== 1'b0 || out_ch !== 3'd0 || out_data !== 8'h00) begin
         n_fail++;
         $display("FAIL async_reset: got v%b c%0d d%h expected v0 c0 d00",
                  out_valid, out_ch, out_data);
      end
      in_valid = 8'b0011_0000;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); @(negedge clk);
      n_tests++;
      if (out_valid !== 1'b1 || out_ch !== 3'd4) begin
         n_fail++;
         $display("FAIL post_reset_grant: got v%b c%0d expected v1 c4", out_valid, out_ch);
      end
   endtask

   task automatic test_sel_out_of_range();
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); @(negedge clk);
         n_tests++;
         if (in_ready5 !== 5'd0 || out_valid5 !== 1'b0) begin
            n_fail++;
            $display("FAIL n5_sel7[%0d]: got r%b v%b expected r0 v0", k, in_ready5, out_valid5);
         end
      end
   endtask

   initial begin
      mon_en = 1'b1;
      rst_n = 1'b0; mode = 1'b0; seleksioni = 3'd0; in_valid = 8'h00; out_ready = 1'b0;
      for (int i = 0; i < 8; i++) in_data[i*8 +: 8] = 8'h10 + 8'(i);
      for (int i = 0; i < 5; i++) in_data5[i*8 +: 8] = 8'h20 + 8'(i);
      in_valid5 = 5'h1F;
      test_reset();
      test_fixed();
      test_rr_all();
      test_rr_wrap();
      test_back_to_back();
      test_fixed_novalid();
      test_async_reset();
      test_sel_out_of_range();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
